pulse_input_conditioner: RTL and testbench

- Upstream stage for the pulse-mode sequential circuit on the EGO1 board.
- Turns three raw, bouncing push-button inputs into clean, mutually exclusive, fixed-width input pulses x1/x2/x3 for the downstream pulse-mode state machine.
- Guarantees the pulse-mode rules: only one input pulses at a time, and there is a minimum quiet gap between pulses, so the downstream y2/y1 state settles before the next pulse.

---
 rtl/pulse_input_conditioner_if.sv | 12 +
 rtl/pulse_input_conditioner.sv | 148 ++++++++++++++
 tb/tb_pulse_input_conditioner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_input_conditioner_if.sv
// Button inputs and conditioned pulse outputs of pulse_input_conditioner.
// The master side drives btn; the slave side (the conditioner) drives x1/x2/x3/busy.
interface pulse_input_conditioner_if;
    logic [2:0] btn;
    logic       x1;
    logic       x2;
    logic       x3;
    logic       busy;

    modport master (output btn, input x1, x2, x3, busy);
    modport slave  (input btn, output x1, x2, x3, busy);
endinterface

// File: rtl/pulse_input_conditioner.sv
// Debounces three push-buttons into exclusive, fixed-width, gap-separated pulses.
// Optional macro PULSE_PENDING_EN queues requests that arrive while busy.
module pulse_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned PULSE_WIDTH     = 4,
    parameter int unsigned GAP_CYCLES      = 16
) (
    input logic                      clk,
    input logic                      rst,
    pulse_input_conditioner_if.slave bus
);
    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMAX = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    deb_q, deb_d;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];
    logic [2:0]    req;
    logic [2:0]    service;
    logic [2:0]    grant;
    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    x;
    logic          busy;
`ifdef PULSE_PENDING_EN
    logic [2:0]    pend_q, pend_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int unsigned i = 0; i < 3; i++) dcnt_q[i] <= '0;
            state_q <= IDLE;
            tcnt_q  <= '0;
            sel_q   <= '0;
`ifdef PULSE_PENDING_EN
            pend_q  <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int unsigned i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            sel_q   <= sel_d;
`ifdef PULSE_PENDING_EN
            pend_q  <= pend_d;
`endif
        end
    end

    // req is taken from the toggle condition itself so the FSM starts the
    // pulse on the same edge the debounced level rises.
    always_comb begin
        sync1_d = bus.btn;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        req     = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    req[i]   = ~deb_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        sel_d   = sel_q;
`ifdef PULSE_PENDING_EN
        pend_d  = pend_q;
        service = req | pend_q;
`else
        service = req;
`endif
        if (service[0])      grant = 3'b001;
        else if (service[1]) grant = 3'b010;
        else if (service[2]) grant = 3'b100;
        else                 grant = 3'b000;

        unique case (state_q)
            IDLE: begin
                if (|service) begin
                    state_d = PULSE;
                    tcnt_d  = '0;
                    sel_d   = grant;
`ifdef PULSE_PENDING_EN
                    pend_d  = service & ~grant;
`endif
                end
            end
            PULSE: begin
`ifdef PULSE_PENDING_EN
                pend_d = pend_q | req;
`endif
                if (tcnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            GAP: begin
`ifdef PULSE_PENDING_EN
                pend_d = pend_q | req;
`endif
                if (tcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    sel_d   = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so rst clears them without waiting for a clock.
    always_comb begin
        x    = (state_q == PULSE) ? sel_q : 3'b000;
        busy = (state_q != IDLE);
    end

    assign bus.x1   = x[0];
    assign bus.x2   = x[1];
    assign bus.x3   = x[2];
    assign bus.busy = busy;
endmodule

// File: tb/tb_pulse_input_conditioner.sv
// Self-checking bench for pulse_input_conditioner (DEBOUNCE=4, PULSE=3, GAP=5).
// Expected pulses are queued at stimulus time and matched by a negedge monitor.
module tb_pulse_input_conditioner;
    localparam int DEB   = 4;
    localparam int PW    = 3;
    localparam int GAP   = 5;
    localparam int LAT   = DEB + 2;
    localparam int SPACE = PW + GAP + 1;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    typedef struct {
        logic [2:0] btn;
        int         hold;
        logic [2:0] exp_plain;
        logic [2:0] exp_pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[7];

    pulse_input_conditioner_if bus ();

    pulse_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_WIDTH(PW),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int ch, input int delay);
        exp_t e;
        e.ch  = ch;
        e.cyc = cyc + delay;
        exp_q.push_back(e);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        check({name, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic monitor();
        logic [2:0] prev;
        logic [2:0] cur;
        logic       busy_prev;
        int         hi_len [3];
        int         busy_len;
        exp_t       e;
        prev      = '0;
        busy_prev = 1'b0;
        busy_len  = 0;
        for (int i = 0; i < 3; i++) hi_len[i] = 0;
        forever begin
            @(negedge clk);
            cur = {bus.x3, bus.x2, bus.x1};
            if (rst) begin
                prev      = '0;
                busy_prev = 1'b0;
                busy_len  = 0;
                for (int i = 0; i < 3; i++) hi_len[i] = 0;
            end else begin
                check("one_hot", $countones(cur) <= 1 ? 1 : 0, 1);
                for (int i = 0; i < 3; i++) begin
                    if (cur[i] && !prev[i]) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_pulse_ch", i, -1);
                        end else begin
                            e = exp_q.pop_front();
                            check("pulse_channel", i, e.ch);
                            check("pulse_rise_cycle", cyc, e.cyc);
                        end
                    end
                    if (cur[i]) begin
                        hi_len[i]++;
                    end else if (prev[i]) begin
                        check("pulse_width", hi_len[i], PW);
                        hi_len[i] = 0;
                    end
                end
                if (bus.busy) begin
                    busy_len++;
                end else if (busy_prev) begin
                    check("busy_len", busy_len, PW + GAP);
                    busy_len = 0;
                end
                prev      = cur;
                busy_prev = bus.busy;
            end
        end
    endtask

    initial begin
        logic [2:0] mask;
        int         k;
        int         base;

        vecs[0] = '{btn: 3'b001, hold: 50, exp_plain: 3'b001, exp_pend: 3'b001};
        vecs[1] = '{btn: 3'b010, hold: 30, exp_plain: 3'b010, exp_pend: 3'b010};
        vecs[2] = '{btn: 3'b100, hold: 30, exp_plain: 3'b100, exp_pend: 3'b100};
        vecs[3] = '{btn: 3'b101, hold: 40, exp_plain: 3'b001, exp_pend: 3'b101};
        vecs[4] = '{btn: 3'b011, hold: 40, exp_plain: 3'b001, exp_pend: 3'b011};
        vecs[5] = '{btn: 3'b110, hold: 40, exp_plain: 3'b010, exp_pend: 3'b110};
        vecs[6] = '{btn: 3'b111, hold: 50, exp_plain: 3'b001, exp_pend: 3'b111};

        fork
            monitor();
        join_none

        bus.btn = '0;
        tick(3);
        check("reset_x", int'({bus.x3, bus.x2, bus.x1}), 0);
        check("reset_busy", int'(bus.busy), 0);
        #2 rst = 1'b0;
        tick(3);

        // Table vectors: every set bit pulses in priority order when pending is built in.
        for (int v = 0; v < 7; v++) begin
`ifdef PULSE_PENDING_EN
            mask = vecs[v].exp_pend;
`else
            mask = vecs[v].exp_plain;
`endif
            bus.btn = vecs[v].btn;
            k = 0;
            for (int c = 0; c < 3; c++) begin
                if (mask[c]) begin
                    expect_pulse(c, LAT + SPACE * k);
                    k++;
                end
            end
            tick(vecs[v].hold);
            bus.btn = '0;
            tick(20);
            drain_check("vector_drain");
        end

        // Bounce shorter than the debounce window.
        for (int t = 0; t < 10; t++) begin
            bus.btn[1] = ~bus.btn[1];
            tick(2);
        end
        bus.btn = '0;
        tick(20);
        check("bounce_deb_level", int'(dut.deb_q[1]), 0);
        drain_check("bounce_drain");

        // btn[1] debounces while x1 is in its gap.
        base = cyc;
        bus.btn = 3'b001;
        expect_pulse(0, LAT);
        tick(4);
        bus.btn = 3'b011;
`ifdef PULSE_PENDING_EN
        exp_q.push_back('{ch: 1, cyc: base + LAT + SPACE});
`endif
        tick(40);
        bus.btn = '0;
        tick(20);
        drain_check("gap_req_drain");

        // Async reset in the second cycle of an x3 pulse, button still held.
        bus.btn = 3'b100;
        expect_pulse(2, LAT);
        tick(LAT + 1);
        check("pre_reset_x3", int'(bus.x3), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_x3", int'(bus.x3), 0);
        check("async_reset_busy", int'(bus.busy), 0);
        tick(2);
        #2 rst = 1'b0;
        expect_pulse(2, LAT);
        tick(30);
        bus.btn = '0;
        tick(20);
        drain_check("reset_held_drain");

        // Back-to-back presses spaced 30 cycles: x1, x2, x1, x3.
        for (int s = 0; s < 4; s++) begin
            int ch;
            ch = (s == 1) ? 1 : (s == 3) ? 2 : 0;
            bus.btn = 3'b000;
            bus.btn[ch] = 1'b1;
            expect_pulse(ch, LAT);
            tick(10);
            bus.btn = '0;
            tick(20);
        end
        tick(10);
        drain_check("sequence_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
